// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, reset/trap vectors and the fetch entry type
package cpu_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] RESET_VEC_D = 32'h8000_0000;
  localparam logic [ADDR_W-1:0] IRQ_VEC_D   = 32'h8000_0004;
  localparam logic [ADDR_W-1:0] EXC_VEC_D   = 32'h8000_0008;
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: small synchronous FIFO of fetched {pc, instr} entries with flush
module prefetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr_q, rptr_q;
  fetch_entry_t mem_q [DEPTH];
  assign empty = wptr_q == rptr_q;
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  // pointers wrap naturally; a flush drops every entry at once
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end
  // storage needs no reset: head is masked to zero while empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner, ROM fetch into prefetch buffer, redirect/trap handling
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VEC = RESET_VEC_D,
  parameter logic [ADDR_W-1:0] IRQ_VEC   = IRQ_VEC_D,
  parameter logic [ADDR_W-1:0] EXC_VEC   = EXC_VEC_D,
  parameter int                DEPTH     = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready,
  input  logic               redir_valid,
  input  logic [ADDR_W-1:0]  redir_pc,
  input  logic               irq,
  input  logic               exc_req,
  output logic               irq_ack,
  output logic [ADDR_W-1:0]  epc
);
  logic [ADDR_W-1:0] pc_q, pc_d, epc_q;
  logic irq_ack_q, full, empty, pop, push, irq_take, flush;
  fetch_entry_t head;
  assign pop      = !empty && id_ready;
  assign irq_take = irq && !pc_q[31] && !exc_req;
  assign flush    = exc_req || irq_take || redir_valid;
  assign push     = !flush && (!full || pop);
  assign pc_d     = exc_req     ? EXC_VEC :
                    irq_take    ? IRQ_VEC :
                    redir_valid ? (redir_pc & ~32'h3) :
                    push        ? pc_q + 32'd4 : pc_q;
  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ('{pc: pc_q, instr: rom_data}),
    .head  (head),
    .full  (full),
    .empty (empty)
  );
  // PC advance and trap bookkeeping; epc points at the oldest unexecuted instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_VEC;
      epc_q     <= '0;
      irq_ack_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      irq_ack_q <= irq_take;
      if (exc_req || irq_take) epc_q <= !empty ? head.pc : pc_q;
    end
  end
  assign rom_addr = pc_q;
  assign if_valid = !empty;
  assign if_instr = head.instr;
  assign if_pc    = head.pc;
  assign irq_ack  = irq_ack_q;
  assign epc      = epc_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random stimulus against a queue-based fetch model
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset, if_valid, id_ready, redir_valid, irq, exc_req, irq_ack;
  logic [31:0] rom_addr, rom_data, if_instr, if_pc, redir_pc, epc;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc, m_epc;
  logic        m_ack;
  int          passed = 0, total = 0;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign rom_data = rom_fn(rom_addr);

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .irq(irq), .exc_req(exc_req),
    .irq_ack(irq_ack), .epc(epc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                      input logic ir, input logic ex);
    logic v;
    reset = r; id_ready = rdy; redir_valid = rv; redir_pc = rpc; irq = ir; exc_req = ex;
    v = mq.size() != 0;
    if (r) begin
      mq.delete(); m_pc = 32'h8000_0000; m_epc = 0; m_ack = 0;
    end else if (ex || (ir && !m_pc[31])) begin
      m_epc = v ? mq[0].pc : m_pc;
      m_pc  = ex ? 32'h8000_0008 : 32'h8000_0004;
      m_ack = !ex;
      mq.delete();
    end else if (rv) begin
      m_pc = rpc & ~32'h3; m_ack = 0; mq.delete();
    end else begin
      m_ack = 0;
      if (v && rdy) void'(mq.pop_front());
      if (mq.size() < 2) begin
        mq.push_back('{m_pc, rom_fn(m_pc)});
        m_pc += 32'd4;
      end
    end
    @(posedge clk); #1;
    chk("rom_addr", rom_addr, m_pc);
    chk("if_valid", {31'b0, if_valid}, {31'b0, mq.size() != 0});
    chk("if_pc", if_pc, mq.size() != 0 ? mq[0].pc : 32'h0);
    chk("if_instr", if_instr, mq.size() != 0 ? mq[0].instr : 32'h0);
    chk("irq_ack", {31'b0, irq_ack}, {31'b0, m_ack});
    chk("epc", epc, m_epc);
  endtask

  initial begin
    logic [31:0] rp;
    step(1, 1, 0, 0, 0, 0);
    chk("reset_addr", rom_addr, 32'h8000_0000);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h0040_0008, 0, 0);
    chk("redir_addr", rom_addr, 32'h0040_0008);
    chk("redir_empty", {31'b0, if_valid}, 32'h0);
    step(0, 1, 0, 0, 0, 0);
    chk("redir_head", if_pc, 32'h0040_0008);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0);
    chk("irq_ack_pulse", {31'b0, irq_ack}, 32'h1);
    chk("irq_epc", epc, 32'h0040_000C);
    chk("irq_vec", rom_addr, 32'h8000_0004);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 0);
    step(0, 1, 1, 32'h0040_0020, 1, 1);
    chk("exc_vec", rom_addr, 32'h8000_0008);
    chk("exc_no_ack", {31'b0, irq_ack}, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("rst_addr", rom_addr, 32'h8000_0000);
    chk("rst_epc", epc, 32'h0);
    chk("rst_empty", {31'b0, if_valid}, 32'h0);
    for (int i = 0; i < 400; i++) begin
      rp = $urandom();
      if ($urandom_range(0, 1) == 0) rp[31] = 1'b0;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           rp, $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
